// File: rtl/pin_rack_fsm.sv
// Bowling pin rack controller: evaluates a roll against the standing pins,
// holds the result for a number of timebase ticks and tracks frame progress.
module pin_rack_fsm #(
    parameter int NUM_PINS   = 10,
    parameter int AIM_W      = 4,
    parameter int POW_W      = 3,
    parameter int AIM_TOL    = 2,
    parameter int POW_TOL    = 1,
    parameter int HOLD_TICKS = 2,
    parameter logic [NUM_PINS*AIM_W-1:0] PIN_POS = 40'h9876543210
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                tick,
    input  logic                throw,
    input  logic                new_rack,
    input  logic [AIM_W-1:0]    aim,
    input  logic [POW_W-1:0]    power,
    input  logic [POW_W-1:0]    target,
    output logic [NUM_PINS-1:0] pins_down,
    output logic [4:0]          knocked,
    output logic                hit,
    output logic                miss,
    output logic                show,
    output logic                roll2,
    output logic                rack_clear,
    output logic                busy
);

    typedef enum logic [1:0] {IDLE, EVAL, HOLD, DONE} state_t;

    localparam logic [AIM_W-1:0] AIM_TOL_L = AIM_W'(AIM_TOL);
    localparam logic [POW_W-1:0] POW_TOL_L = POW_W'(POW_TOL);
    localparam logic [3:0]       TICK_LAST = 4'(HOLD_TICKS - 1);

    state_t              state, state_nxt;
    logic [AIM_W-1:0]    aim_p0;
    logic [POW_W-1:0]    power_p0, target_p0;
    logic                ld_p0;
    logic [NUM_PINS-1:0] hitmask, pins_nxt;
    logic [4:0]          knocked_nxt;
    logic                hit_nxt, miss_nxt, show_nxt, roll2_nxt, clear_nxt;
    logic [3:0]          tick_cnt, tick_nxt;
    logic                pow_ok;

    // Distances are taken as larger minus smaller so they never wrap.
    function automatic logic [AIM_W-1:0] aim_dist(input logic [AIM_W-1:0] a,
                                                  input logic [AIM_W-1:0] b);
        return (a >= b) ? a - b : b - a;
    endfunction

    function automatic logic [POW_W-1:0] pow_dist(input logic [POW_W-1:0] a,
                                                  input logic [POW_W-1:0] b);
        return (a >= b) ? a - b : b - a;
    endfunction

    function automatic logic [4:0] pop_count(input logic [NUM_PINS-1:0] m);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < NUM_PINS; i++) c = c + {4'b0, m[i]};
        return c;
    endfunction

    // Stage p0: roll operands captured when a throw is accepted
    always_ff @(posedge CLOCK_50) begin
        if (ld_p0) begin
            aim_p0    <= aim;
            power_p0  <= power;
            target_p0 <= target;
        end
    end

    always_comb begin
        pow_ok = (pow_dist(power_p0, target_p0) <= POW_TOL_L);
        for (int i = 0; i < NUM_PINS; i++)
            hitmask[i] = ~pins_down[i] & pow_ok &
                         (aim_dist(aim_p0, PIN_POS[i*AIM_W +: AIM_W]) <= AIM_TOL_L);
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        pins_nxt    = pins_down;
        knocked_nxt = knocked;
        hit_nxt     = hit;
        miss_nxt    = miss;
        show_nxt    = show;
        roll2_nxt   = roll2;
        clear_nxt   = rack_clear;
        tick_nxt    = tick_cnt;
        ld_p0       = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (new_rack) begin
                    state_nxt   = IDLE;
                    pins_nxt    = '0;
                    knocked_nxt = '0;
                    hit_nxt     = 1'b0;
                    miss_nxt    = 1'b0;
                    show_nxt    = 1'b0;
                    roll2_nxt   = 1'b0;
                    clear_nxt   = 1'b0;
                    tick_nxt    = '0;
                end else if (throw) begin
                    state_nxt   = EVAL;
                    ld_p0       = 1'b1;
                    knocked_nxt = '0;
                    hit_nxt     = 1'b0;
                    miss_nxt    = 1'b0;
                    show_nxt    = 1'b0;
                    // A finished frame is re-stood before the new roll is judged.
                    if (rack_clear) begin
                        pins_nxt  = '0;
                        roll2_nxt = 1'b0;
                        clear_nxt = 1'b0;
                    end
                end
            end
            EVAL: begin
                state_nxt   = HOLD;
                pins_nxt    = pins_down | hitmask;
                knocked_nxt = pop_count(hitmask);
                hit_nxt     = |hitmask;
                miss_nxt    = ~|hitmask;
                tick_nxt    = '0;
            end
            HOLD: begin
                if (tick) begin
                    if (tick_cnt == TICK_LAST) begin
                        state_nxt = DONE;
                        show_nxt  = 1'b1;
                        tick_nxt  = '0;
                        if (roll2 || (&pins_down)) clear_nxt = 1'b1;
                        else                       roll2_nxt = 1'b1;
                    end else begin
                        tick_nxt = tick_cnt + 4'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            pins_down  <= '0;
            knocked    <= '0;
            hit        <= 1'b0;
            miss       <= 1'b0;
            show       <= 1'b0;
            roll2      <= 1'b0;
            rack_clear <= 1'b0;
            tick_cnt   <= '0;
        end else begin
            pins_down  <= pins_nxt;
            knocked    <= knocked_nxt;
            hit        <= hit_nxt;
            miss       <= miss_nxt;
            show       <= show_nxt;
            roll2      <= roll2_nxt;
            rack_clear <= clear_nxt;
            tick_cnt   <= tick_nxt;
        end
    end

    assign busy = (state == EVAL) || (state == HOLD);

endmodule

// File: tb/tb_pin_rack_fsm.sv
// Directed bench for pin_rack_fsm at default parameters; expected values are
// worked out by hand from pin i standing at lane position i.
module tb_pin_rack_fsm;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b0;
    logic       tick     = 1'b0;
    logic       throw    = 1'b0;
    logic       new_rack = 1'b0;
    logic [3:0] aim      = '0;
    logic [2:0] power    = '0;
    logic [2:0] target   = '0;
    logic [9:0] pins_down;
    logic [4:0] knocked;
    logic       hit, miss, show, roll2, rack_clear, busy;

    int n_checks = 0;
    int n_pass   = 0;

    pin_rack_fsm dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .tick       (tick),
        .throw      (throw),
        .new_rack   (new_rack),
        .aim        (aim),
        .power      (power),
        .target     (target),
        .pins_down  (pins_down),
        .knocked    (knocked),
        .hit        (hit),
        .miss       (miss),
        .show       (show),
        .roll2      (roll2),
        .rack_clear (rack_clear),
        .busy       (busy)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic do_throw(input logic [3:0] a, input logic [2:0] p, input logic [2:0] t);
        aim = a; power = p; target = t; throw = 1'b1;
        step();
        throw = 1'b0;
    endtask

    task automatic give_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            tick = 1'b1; step(); tick = 1'b0; step();
        end
    endtask

    task automatic pulse_new_rack();
        new_rack = 1'b1; step(); new_rack = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check_eq({tag, "_pins"},  pins_down, 0);
        check_eq({tag, "_knock"}, knocked, 0);
        check_eq({tag, "_hit"},   hit, 0);
        check_eq({tag, "_miss"},  miss, 0);
        check_eq({tag, "_show"},  show, 0);
        check_eq({tag, "_roll2"}, roll2, 0);
        check_eq({tag, "_clear"}, rack_clear, 0);
        check_eq({tag, "_busy"},  busy, 0);
    endtask

    initial begin
        step(); step();
        check_cleared("rst");
        reset = 1'b1;
        step();

        // First roll: pins 3..7 fall
        do_throw(4'd5, 3'd4, 3'd5);
        check_eq("r1_busy_eval", busy, 1);
        step();
        check_eq("r1_pins", pins_down, 10'h0F8);
        check_eq("r1_knock", knocked, 5);
        check_eq("r1_hit", hit, 1);
        check_eq("r1_miss", miss, 0);
        check_eq("r1_show_early", show, 0);
        give_ticks(1);
        check_eq("r1_show_1tick", show, 0);
        check_eq("r1_busy_hold", busy, 1);
        give_ticks(1);
        check_eq("r1_show", show, 1);
        check_eq("r1_roll2", roll2, 1);
        check_eq("r1_clear", rack_clear, 0);
        check_eq("r1_busy_done", busy, 0);

        // Second roll at fallen pins; a tick during EVAL must not count
        do_throw(4'd5, 3'd4, 3'd5);
        check_eq("r2_show_clr", show, 0);
        check_eq("r2_hit_clr", hit, 0);
        tick = 1'b1; step(); tick = 1'b0;
        check_eq("r2_knock", knocked, 0);
        check_eq("r2_miss", miss, 1);
        check_eq("r2_hit", hit, 0);
        give_ticks(1);
        check_eq("r2_eval_tick", show, 0);
        give_ticks(1);
        check_eq("r2_show", show, 1);
        check_eq("r2_clear", rack_clear, 1);
        step(); step();
        check_eq("r2_hold_miss", miss, 1);
        check_eq("r2_hold_show", show, 1);

        // Throw after a cleared frame re-stands the rack
        do_throw(4'd5, 3'd4, 3'd5);
        check_eq("r3_clear", rack_clear, 0);
        check_eq("r3_roll2", roll2, 0);
        check_eq("r3_pins0", pins_down, 0);
        step();
        check_eq("r3_knock", knocked, 5);
        check_eq("r3_pins", pins_down, 10'h0F8);
        give_ticks(2);
        check_eq("r3_roll2_after", roll2, 1);

        // throw and new_rack together: new_rack wins
        aim = 4'd5; power = 3'd4; target = 3'd5;
        throw = 1'b1; new_rack = 1'b1; step(); throw = 1'b0; new_rack = 1'b0;
        check_cleared("nr");
        step();
        check_eq("nr_busy_next", busy, 0);

        // Power out of tolerance
        do_throw(4'd5, 3'd0, 3'd7);
        step();
        check_eq("pw_knock", knocked, 0);
        check_eq("pw_miss", miss, 1);
        check_eq("pw_pins", pins_down, 0);
        give_ticks(2);
        pulse_new_rack();
        check_eq("pw_nr_roll2", roll2, 0);

        // Lane edges: aim 0 hits pins 0..2, aim 15 must not wrap onto pin 0/1
        do_throw(4'd0, 3'd5, 3'd4);
        step();
        check_eq("e0_knock", knocked, 3);
        check_eq("e0_pins", pins_down, 10'h007);
        give_ticks(2);
        do_throw(4'd15, 3'd5, 3'd4);
        step();
        check_eq("e15_knock", knocked, 0);
        check_eq("e15_miss", miss, 1);
        check_eq("e15_pins", pins_down, 10'h007);
        give_ticks(2);
        check_eq("e15_clear", rack_clear, 1);

        // new_rack and throw ignored in HOLD, then reset mid-HOLD
        pulse_new_rack();
        do_throw(4'd5, 3'd4, 3'd5);
        step();
        pulse_new_rack();
        check_eq("hold_nr_pins", pins_down, 10'h0F8);
        check_eq("hold_nr_busy", busy, 1);
        give_ticks(1);
        do_throw(4'd0, 3'd5, 3'd4);
        check_eq("hold_thr_knock", knocked, 5);
        check_eq("hold_thr_busy", busy, 1);
        reset = 1'b0; step();
        check_cleared("rst_hold");
        reset = 1'b1; step();
        do_throw(4'd5, 3'd4, 3'd5);
        step();
        check_eq("post_rst_knock", knocked, 5);
        check_eq("post_rst_pins", pins_down, 10'h0F8);
        give_ticks(2);
        check_eq("post_rst_show", show, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
